// File: rtl/store_write_buffer_if.sv
// Store request, MemoryController byte-write and completion signals of the store write buffer.
interface store_write_buffer_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int RAM_WIDTH  = 8
);
   logic                  req_valid_in;
   logic                  req_ready_out;
   logic [ADDR_WIDTH-1:0] req_address_in;
   logic [DATA_WIDTH-1:0] req_data_in;
   logic [1:0]            req_size_in;
   logic                  mc_ready_in;
   logic                  mc_rw_signal_out;
   logic [ADDR_WIDTH-1:0] mc_address_out;
   logic [RAM_WIDTH-1:0]  mc_data_out;
   logic                  done_out;
   logic [ADDR_WIDTH-1:0] done_address_out;
   logic                  empty_out;

   modport slave (
      input  req_valid_in, req_address_in, req_data_in, req_size_in, mc_ready_in,
      output req_ready_out, mc_rw_signal_out, mc_address_out, mc_data_out,
      output done_out, done_address_out, empty_out
   );

   modport master (
      output req_valid_in, req_address_in, req_data_in, req_size_in, mc_ready_in,
      input  req_ready_out, mc_rw_signal_out, mc_address_out, mc_data_out,
      input  done_out, done_address_out, empty_out
   );
endinterface

// File: rtl/store_write_buffer.sv
// Queues committed 1/2/4-byte stores and serialises each into little-endian byte writes,
// pulsing done per store and flagging when fully drained.
module store_write_buffer #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int RAM_WIDTH  = 8,
   parameter int DEPTH      = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   store_write_buffer_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int IDX_W = $clog2(DATA_WIDTH / RAM_WIDTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [ADDR_WIDTH-1:0] r_fifo_addr [DEPTH];
   logic [DATA_WIDTH-1:0] r_fifo_data [DEPTH];
   logic [IDX_W-1:0]      r_fifo_last [DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;

   logic [1:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [DATA_WIDTH-1:0] r_data;
   logic [IDX_W-1:0]      r_last;
   logic [IDX_W-1:0]      r_idx;

   logic                  w_push;
   logic                  w_pop;

   // Index of the final byte: size 00 -> 0, 01 -> 1, 10/11 -> last byte of the word.
   function automatic logic [IDX_W-1:0] last_index(input logic [1:0] size);
      case (size)
         2'b00:   return '0;
         2'b01:   return IDX_W'(1);
         default: return IDX_W'(DATA_WIDTH / RAM_WIDTH - 1);
      endcase
   endfunction

   assign bus.req_ready_out = (r_count != CNT_W'(DEPTH));
   assign w_push            = bus.req_valid_in && bus.req_ready_out;
   assign w_pop             = (r_state == S_IDLE) && (r_count != '0);
   assign bus.empty_out     = (r_count == '0) && (r_state == S_IDLE);

   // NOTE: FIFO storage has no reset; r_count alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= bus.req_address_in;
         r_fifo_data[r_wr_ptr] <= bus.req_data_in;
         r_fifo_last[r_wr_ptr] <= last_index(bus.req_size_in);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state              <= S_IDLE;
         r_base               <= '0;
         r_data               <= '0;
         r_last               <= '0;
         r_idx                <= '0;
         bus.mc_rw_signal_out <= 1'b0;
         bus.mc_address_out   <= '0;
         bus.mc_data_out      <= '0;
         bus.done_out         <= 1'b0;
         bus.done_address_out <= '0;
      end else begin
         // Bus outputs idle every cycle unless a state below drives them.
         bus.mc_rw_signal_out <= 1'b0;
         bus.mc_address_out   <= '0;
         bus.mc_data_out      <= '0;
         bus.done_out         <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_base  <= r_fifo_addr[r_rd_ptr];
                  r_data  <= r_fifo_data[r_rd_ptr];
                  r_last  <= r_fifo_last[r_rd_ptr];
                  r_idx   <= '0;
                  r_state <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (bus.mc_ready_in) begin
                  bus.mc_rw_signal_out <= 1'b1;
                  bus.mc_address_out   <= r_base + ADDR_WIDTH'(r_idx);
                  bus.mc_data_out      <= r_data[int'(r_idx) * RAM_WIDTH +: RAM_WIDTH];
                  r_idx                <= r_idx + 1'b1;
                  if (r_idx == r_last) r_state <= S_DONE;
               end
            end
            S_DONE: begin
               bus.done_out         <= 1'b1;
               bus.done_address_out <= r_base;
               r_state              <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: stimulus queues expected byte writes and done pulses,
// an independent negedge monitor pops and compares them whenever the DUT presents output.
module tb_store_write_buffer;
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   store_write_buffer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RAM_WIDTH(8)) bus ();

   store_write_buffer #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .RAM_WIDTH(8), .DEPTH(4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct packed {
      logic        is_done;
      logic [31:0] addr;
      logic [7:0]  data;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic exp_wr(input logic [31:0] a, input logic [7:0] d);
      sb_q.push_back('{is_done: 1'b0, addr: a, data: d});
   endtask

   task automatic exp_done(input logic [31:0] a);
      sb_q.push_back('{is_done: 1'b1, addr: a, data: 8'h00});
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (bus.mc_rw_signal_out === 1'b1 || bus.done_out === 1'b1) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: rw=%b addr=%h data=%h done=%b done_addr=%h, expected nothing",
                     bus.mc_rw_signal_out, bus.mc_address_out, bus.mc_data_out,
                     bus.done_out, bus.done_address_out);
         end else begin
            e = sb_q.pop_front();
            if (e.is_done) begin
               check("done_pulse", 32'(bus.done_out), 32'd1);
               check("done_no_write", 32'(bus.mc_rw_signal_out), 32'd0);
               check("done_addr", bus.done_address_out, e.addr);
            end else begin
               check("wr_rw", 32'(bus.mc_rw_signal_out), 32'd1);
               check("wr_no_done", 32'(bus.done_out), 32'd0);
               check("wr_addr", bus.mc_address_out, e.addr);
               check("wr_data", 32'(bus.mc_data_out), 32'(e.data));
            end
         end
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      int waited = 0;
      @(negedge clk);
      while (bus.req_ready_out !== 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 100) begin
         total++;
         bad++;
         $display("FAIL send_timeout: req_ready_out=%b, expected 1 within 100 cycles", bus.req_ready_out);
      end else begin
         bus.req_valid_in   = 1'b1;
         bus.req_address_in = a;
         bus.req_data_in    = d;
         bus.req_size_in    = s;
         @(posedge clk);
         #1;
         bus.req_valid_in   = 1'b0;
      end
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!(bus.empty_out === 1'b1 && sb_q.size() == 0) && n < 300);
      if (n >= 300) begin
         total++;
         bad++;
         $display("FAIL %s_drain_timeout: empty=%b pending=%0d, expected empty=1 pending=0",
                  name, bus.empty_out, sb_q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid_in   = 1'b0;
      bus.req_address_in = '0;
      bus.req_data_in    = '0;
      bus.req_size_in    = 2'b00;
      bus.mc_ready_in    = 1'b1;
      rst_n              = 1'b0;
      #12;
      check("rst_rw", 32'(bus.mc_rw_signal_out), 32'd0);
      check("rst_addr", bus.mc_address_out, 32'h0);
      check("rst_data", 32'(bus.mc_data_out), 32'h0);
      check("rst_done", 32'(bus.done_out), 32'd0);
      check("rst_done_addr", bus.done_address_out, 32'h0);
      check("rst_ready", 32'(bus.req_ready_out), 32'd1);
      check("rst_empty", 32'(bus.empty_out), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: word store, latency and back-to-back bytes
      exp_wr(32'h100, 8'h44);
      exp_wr(32'h101, 8'h33);
      exp_wr(32'h102, 8'h22);
      exp_wr(32'h103, 8'h11);
      exp_done(32'h100);
      send(32'h100, 32'h1122_3344, 2'b10);
      check("t1_empty_low", 32'(bus.empty_out), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("t1_pop_cycle_idle", 32'(bus.mc_rw_signal_out), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t1_byte_cycle", 32'(bus.mc_rw_signal_out), 32'd1);
      end
      @(negedge clk);
      check("t1_done_cycle", 32'(bus.done_out), 32'd1);
      check("t1_empty_at_done", 32'(bus.empty_out), 32'd1);
      wait_drain("t1");

      // 2: single byte ignores upper data bytes
      exp_wr(32'h3_0000, 8'hAB);
      exp_done(32'h3_0000);
      send(32'h3_0000, 32'hFFFF_FFAB, 2'b00);
      check("t2_empty_low", 32'(bus.empty_out), 32'd0);
      wait_drain("t2");
      check("t2_empty_back", 32'(bus.empty_out), 32'd1);

      // 3: halfword with a three-cycle MemoryController stall after the first byte
      exp_wr(32'h20, 8'hEF);
      exp_wr(32'h21, 8'hBE);
      exp_done(32'h20);
      send(32'h20, 32'h0000_BEEF, 2'b01);
      @(posedge clk);
      @(posedge clk);
      #1 bus.mc_ready_in = 1'b0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         check("t3_stall_rw", 32'(bus.mc_rw_signal_out), 32'd0);
      end
      bus.mc_ready_in = 1'b1;
      wait_drain("t3");

      // 4: five back-to-back words with MemoryController stalled; FIFO fills, order preserved
      bus.mc_ready_in = 1'b0;
      for (int k = 0; k < 5; k++) begin
         for (int b = 0; b < 4; b++) exp_wr(32'h200 + 32'(16 * k + b), 8'(16 * k + b));
         exp_done(32'h200 + 32'(16 * k));
      end
      send(32'h200, 32'h0302_0100, 2'b10);
      send(32'h210, 32'h1312_1110, 2'b10);
      send(32'h220, 32'h2322_2120, 2'b10);
      send(32'h230, 32'h3332_3130, 2'b10);
      check("t4_ready_before_last", 32'(bus.req_ready_out), 32'd1);
      send(32'h240, 32'h4342_4140, 2'b10);
      check("t4_ready_full", 32'(bus.req_ready_out), 32'd0);
      @(negedge clk);
      check("t4_ready_still_full", 32'(bus.req_ready_out), 32'd0);
      check("t4_stalled_rw", 32'(bus.mc_rw_signal_out), 32'd0);
      bus.mc_ready_in = 1'b1;
      wait_drain("t4");

      // 5: reset after the second byte abandons the rest of the store
      exp_wr(32'h400, 8'h0D);
      exp_wr(32'h401, 8'hF0);
      send(32'h400, 32'hCAFE_F00D, 2'b10);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_rw", 32'(bus.mc_rw_signal_out), 32'd0);
      check("t5_rst_addr", bus.mc_address_out, 32'h0);
      check("t5_rst_data", 32'(bus.mc_data_out), 32'h0);
      check("t5_rst_done", 32'(bus.done_out), 32'd0);
      check("t5_rst_ready", 32'(bus.req_ready_out), 32'd1);
      check("t5_rst_empty", 32'(bus.empty_out), 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("t5_empty_after", 32'(bus.empty_out), 32'd1);
      check("t5_pending", 32'(sb_q.size()), 32'd0);

      // 6: address wrap, size 11 treated as a word
      exp_wr(32'hFFFF_FFFE, 8'hEF);
      exp_wr(32'hFFFF_FFFF, 8'hBE);
      exp_wr(32'h0000_0000, 8'hAD);
      exp_wr(32'h0000_0001, 8'hDE);
      exp_done(32'hFFFF_FFFE);
      send(32'hFFFF_FFFE, 32'hDEAD_BEEF, 2'b11);
      wait_drain("t6");

      repeat (3) @(negedge clk);
      check("final_pending", 32'(sb_q.size()), 32'd0);
      check("final_empty", 32'(bus.empty_out), 32'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
